timer_ctrl: RTL and testbench

- Control FSM that sequences an 8-bit up-counter timer: start, pause, resume, clear, programmable terminal count and optional auto-reload.
- Contains its own prescaler, so the counter advances once every PRESCALE clocks.
- Produces a one-cycle expiry pulse and status for the display and top-level logic.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/tick_gen.sv | 59 +++++
 rtl/timer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_timer_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the timer control block: FSM state encoding and
//   the default counter width.
// -----------------------------------------------------------------------------
package timer_pkg;

    // Default counter / limit width.
    localparam int CNT_W_DEFAULT = 8;

    // FSM state encoding. The encoding is visible on the state output port,
    // so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // True in the states where a start command is acted upon.
    function automatic logic start_allowed(input state_e s);
        return (s != ST_RUN);
    endfunction

endpackage : timer_pkg

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Prescaler for the timer. While enabled it counts 0..PRESCALE-1 and
//   raises tick during the cycle in which it sits at PRESCALE-1; on that edge
//   it wraps to 0. While disabled it holds its value. zero forces it back to
//   0 and suppresses tick.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_start  in   synchronous active-high reset
//   enable       in   advance the prescaler this cycle
//   zero         in   clear the prescaler this cycle (wins over enable)
//   tick         out  combinational: enable && prescaler == PRESCALE-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int PRESCALE = 10
) (
    input  logic clock,
    input  logic reset_start,
    input  logic enable,
    input  logic zero,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        presc_d = presc_q;
        tick    = 1'b0;

        if (zero) begin
            presc_d = '0;
        end else if (enable) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset_start) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_gen

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Control FSM for an up-counting timer with built-in prescaler, pause /
//   resume, clear, programmable terminal count and optional auto-reload.
//   The counter advances once per prescaler tick while in RUN.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_start  in   synchronous active-high reset, beats every command
//   start        in   start (IDLE/DONE) or resume (PAUSE)
//   stop         in   pause, effective only in RUN
//   clear        in   back to IDLE with counter zeroed, limit kept
//   load         in   latch limit_in into the limit register (not in RUN)
//   limit_in     in   new terminal count
//   auto_reload  in   1: wrap to 0 at the limit and keep running
//                     0: hold the count and stop in DONE
//   counter      out  current count (registered)
//   limit        out  active terminal count (registered)
//   running      out  high only while state is RUN (registered)
//   expired      out  one-cycle pulse after a terminal tick (registered)
//   state        out  IDLE=00, RUN=01, PAUSE=10, DONE=11 (registered)
//
// Command priority in one cycle: clear > stop > start > load. A command that
// has no effect in the current state (stop outside RUN, start in RUN) does
// not block the ones below it.
//
// The prescaler advances on every edge taken from RUN, including the edge
// on which stop is accepted, so a pause/resume never loses or adds a clock
// of RUN time. If a terminal tick without auto-reload coincides with stop,
// the count has finished and the FSM goes to DONE rather than PAUSE.
// -----------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter int PRESCALE      = 10,
    parameter int DEFAULT_LIMIT = 99
) (
    input  logic             clock,
    input  logic             reset_start,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] limit_in,
    input  logic             auto_reload,
    output logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] limit,
    output logic             running,
    output logic             expired,
    output logic [1:0]       state
);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   limit_q,   limit_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;

    logic               tick;
    logic               presc_zero;
    logic               terminal;

    // The prescaler only runs in RUN; it is held in PAUSE and forced to 0 in
    // IDLE and DONE, and on a clear from any state.
    assign presc_zero = clear || (state_q == ST_IDLE) || (state_q == ST_DONE);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clock       (clock),
        .reset_start (reset_start),
        .enable      (state_q == ST_RUN),
        .zero        (presc_zero),
        .tick        (tick)
    );

    // >= rather than == so a limit lowered below the count during PAUSE
    // expires on the first tick after resume instead of running to 2^CNT_W.
    assign terminal = (counter_q >= limit_q);

    // ---------------------------------------------------------------------
    // State register (plus the registered datapath and outputs)
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset_start) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            limit_q   <= CNT_W'(DEFAULT_LIMIT);
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            limit_q   <= limit_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (tick && terminal && !auto_reload) begin
                        state_d = ST_DONE;
                    end else if (stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_IDLE, ST_PAUSE, ST_DONE: begin
                    if (start_allowed(state_q) && start) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output / datapath logic: counter, limit, expiry and running flag
    // ---------------------------------------------------------------------
    always_comb begin
        counter_d = counter_q;
        limit_d   = limit_q;
        expired_d = 1'b0;

        if (!clear) begin
            unique case (state_q)
                ST_RUN: begin
                    // Limit is frozen while counting; only ticks move the count.
                    if (tick) begin
                        if (terminal) begin
                            expired_d = 1'b1;
                            if (auto_reload) begin
                                counter_d = '0;
                            end
                        end else begin
                            counter_d = counter_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // A restart from DONE begins a fresh count.
                    if (start) begin
                        counter_d = '0;
                    end else if (load) begin
                        limit_d = limit_in;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (!start && load) begin
                        limit_d = limit_in;
                    end
                end
                default: begin
                    counter_d = '0;
                end
            endcase
        end else begin
            counter_d = '0;
        end

        running_d = (state_d == ST_RUN);
    end

    assign counter = counter_q;
    assign limit   = limit_q;
    assign running = running_q;
    assign expired = expired_q;
    assign state   = state_q;

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed scenarios followed by a randomized run, every cycle compared
//   against a behavioural model of the timer kept in this bench.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int PRESCALE = 10;
    localparam int CNT_W    = 8;
    localparam int DEF_LIM  = 99;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic             clock       = 1'b0;
    logic             reset_start = 1'b1;
    logic             start       = 1'b0;
    logic             stop        = 1'b0;
    logic             clear       = 1'b0;
    logic             load        = 1'b0;
    logic             auto_reload = 1'b0;
    logic [CNT_W-1:0] limit_in    = '0;

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] limit;
    logic             running;
    logic             expired;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_state = S_IDLE;
    int m_pre   = 0;
    int m_cnt   = 0;
    int m_lim   = DEF_LIM;
    int m_exp   = 0;

    always #5 clock = ~clock;

    timer_ctrl #(
        .CNT_W         (CNT_W),
        .PRESCALE      (PRESCALE),
        .DEFAULT_LIMIT (DEF_LIM)
    ) dut (
        .clock       (clock),
        .reset_start (reset_start),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .load        (load),
        .limit_in    (limit_in),
        .auto_reload (auto_reload),
        .counter     (counter),
        .limit       (limit),
        .running     (running),
        .expired     (expired),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        int ns   = m_state;
        int npre = m_pre;
        int ncnt = m_cnt;
        int nlim = m_lim;
        int nexp = 0;
        if (reset_start) begin
            ns = S_IDLE; npre = 0; ncnt = 0; nlim = DEF_LIM;
        end else if (clear) begin
            ns = S_IDLE; npre = 0; ncnt = 0;
        end else if (m_state == S_RUN) begin
            npre = (m_pre + 1) % PRESCALE;
            if (m_pre == PRESCALE - 1) begin
                if (m_cnt >= m_lim) begin
                    nexp = 1;
                    if (auto_reload) ncnt = 0;
                    else             ns   = S_DONE;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end
            if (stop && ns == S_RUN) ns = S_PAUSE;
        end else begin
            // IDLE, PAUSE and DONE all honour start, else load
            if (start) begin
                ns = S_RUN;
                if (m_state == S_DONE) begin
                    ncnt = 0; npre = 0;
                end
            end else if (load) begin
                nlim = int'(limit_in);
            end
        end
        m_state = ns; m_pre = npre; m_cnt = ncnt; m_lim = nlim; m_exp = nexp;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check("counter", 32'(counter), 32'(m_cnt));
        check("limit",   32'(limit),   32'(m_lim));
        check("state",   32'(state),   32'(m_state));
        check("running", 32'(running), 32'(m_state == S_RUN));
        check("expired", 32'(expired), 32'(m_exp));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin : stim
        int run_edges;
        int guard;
        int exp_count;
        int back_to_back;
        logic prev_exp;

        // ---- reset, then start at the 25 ns edge ----
        reset_start = 1'b1;
        step();                      // 5 ns
        step();                      // 15 ns
        check("reset_state",   32'(state),   32'(S_IDLE));
        check("reset_limit",   32'(limit),   32'(DEF_LIM));
        check("reset_running", 32'(running), 32'(0));
        reset_start = 1'b0;
        start       = 1'b1;
        step();                      // 25 ns: start edge
        start = 1'b0;
        check("start_running", 32'(running), 32'(1));
        run(9);
        check("cnt_before_tick", 32'(counter), 32'(0));
        step();
        check("cnt_first_tick", 32'(counter), 32'(1));
        run(980);
        check("cnt_99", 32'(counter), 32'(99));
        run(9);
        check("no_early_expire", 32'(expired), 32'(0));
        step();
        check("terminal_expired", 32'(expired), 32'(1));
        check("terminal_done",    32'(state),   32'(S_DONE));
        step();
        check("expired_one_cycle", 32'(expired), 32'(0));
        check("done_hold_99",      32'(counter), 32'(99));

        // ---- pause / resume keeps prescaler phase ----
        start = 1'b1; step(); start = 1'b0;   // DONE -> RUN, counter 0
        check("restart_cnt0", 32'(counter), 32'(0));
        run(53);
        run_edges = 53;
        check("pause_cnt5", 32'(counter), 32'(5));
        stop = 1'b1; step(); stop = 1'b0;
        run_edges++;
        check("paused", 32'(state), 32'(S_PAUSE));
        run(50);
        check("pause_hold5", 32'(counter), 32'(5));
        start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (counter !== 8'd6 && guard < 100) begin
            if (state === 2'(S_RUN)) run_edges++;
            step();
            guard++;
        end
        check("pause_run_edges", 32'(run_edges), 32'(60));

        // ---- limit 3 with auto-reload ----
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_idle", 32'(state), 32'(S_IDLE));
        limit_in = 8'd3; load = 1'b1; step(); load = 1'b0;
        check("load3", 32'(limit), 32'(3));
        auto_reload = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        exp_count = 0;
        repeat (120) begin
            step();
            exp_count += int'(expired);
        end
        check("reload_expire_count", 32'(exp_count), 32'(3));
        check("reload_stays_run",    32'(state),     32'(S_RUN));

        // ---- limit lowered below counter while paused ----
        clear = 1'b1; step(); clear = 1'b0;
        auto_reload = 1'b0;
        limit_in = 8'd99; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run(70);
        check("lower_cnt7", 32'(counter), 32'(7));
        stop = 1'b1; step(); stop = 1'b0;
        limit_in = 8'd4; load = 1'b1; step(); load = 1'b0;
        check("lower_load4", 32'(limit), 32'(4));
        start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (expired !== 1'b1 && guard < 30) begin
            step();
            guard++;
        end
        check("lower_expired", 32'(expired), 32'(1));
        check("lower_done",    32'(state),   32'(S_DONE));
        check("lower_cnt_kept", 32'(counter), 32'(7));

        // ---- limit 0 with auto-reload ----
        clear = 1'b1; step(); clear = 1'b0;
        limit_in = 8'd0; load = 1'b1; step(); load = 1'b0;
        auto_reload = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        exp_count = 0; back_to_back = 0; prev_exp = 1'b0;
        repeat (50) begin
            step();
            if (expired && prev_exp) back_to_back++;
            exp_count += int'(expired);
            prev_exp = expired;
        end
        check("lim0_expire_count", 32'(exp_count),    32'(5));
        check("lim0_back_to_back", 32'(back_to_back), 32'(0));
        check("lim0_cnt0",         32'(counter),      32'(0));

        // ---- clear + stop + start together in RUN ----
        clear = 1'b1; step(); clear = 1'b0;
        auto_reload = 1'b0;
        limit_in = 8'd99; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run(200);
        check("combo_cnt20", 32'(counter), 32'(20));
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        check("combo_idle",  32'(state),   32'(S_IDLE));
        check("combo_cnt0",  32'(counter), 32'(0));
        check("combo_limit", 32'(limit),   32'(99));

        // ---- reset mid-run restores the default limit ----
        limit_in = 8'd42; load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run(30);
        reset_start = 1'b1; step(); reset_start = 1'b0;
        check("rst_state",   32'(state),   32'(S_IDLE));
        check("rst_counter", 32'(counter), 32'(0));
        check("rst_limit",   32'(limit),   32'(DEF_LIM));
        check("rst_expired", 32'(expired), 32'(0));

        // ---- randomized commands against the model ----
        repeat (4000) begin
            reset_start = ($urandom_range(0, 399) == 0);
            clear       = ($urandom_range(0, 49) == 0);
            stop        = ($urandom_range(0, 19) == 0);
            start       = ($urandom_range(0, 14) == 0);
            load        = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 99) == 0) auto_reload = ~auto_reload;
            limit_in    = 8'($urandom_range(0, 12));
            step();
        end
        reset_start = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0; load = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_ctrl
